// File: rtl/rs_issue_queue_if.sv
// Dispatch, writeback, flush and issue signals of the reservation station.
// master = rename/ROB/execute side, slave = the reservation station.
interface rs_issue_queue_if #(
  parameter int OPW = 16
);
  logic           disp_valid;
  logic [7:0]     disp_robid;
  logic [OPW-1:0] disp_op;
  logic           disp_rs1_valid;
  logic [31:0]    disp_rs1_tagval;
  logic           disp_rs2_valid;
  logic [31:0]    disp_rs2_tagval;
  logic           rs_full;

  logic           wb_valid;
  logic           wb_error;
  logic [7:0]     wb_robid;
  logic [31:0]    wb_result;

  logic           rob_flush;

  logic           issue_valid;
  logic           issue_ready;
  logic [7:0]     issue_robid;
  logic [OPW-1:0] issue_op;
  logic [31:0]    issue_rs1;
  logic [31:0]    issue_rs2;

  modport master (
    output disp_valid, disp_robid, disp_op, disp_rs1_valid, disp_rs1_tagval,
           disp_rs2_valid, disp_rs2_tagval,
           wb_valid, wb_error, wb_robid, wb_result,
           rob_flush, issue_ready,
    input  rs_full, issue_valid, issue_robid, issue_op, issue_rs1, issue_rs2
  );

  modport slave (
    input  disp_valid, disp_robid, disp_op, disp_rs1_valid, disp_rs1_tagval,
           disp_rs2_valid, disp_rs2_tagval,
           wb_valid, wb_error, wb_robid, wb_result,
           rob_flush, issue_ready,
    output rs_full, issue_valid, issue_robid, issue_op, issue_rs1, issue_rs2
  );
endinterface

// File: rtl/rs_issue_queue.sv
// Unified reservation station: dispatch into lowest free slot, writeback snoop
// with dispatch-time bypass, lowest-index ready entry issued per cycle.
module rs_issue_queue #(
  parameter int DEPTH = 8,
  parameter int OPW   = 16
) (
  input  logic             clk,
  input  logic             rst,
  rs_issue_queue_if.slave  bus
);
  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DEPTH-1:0] valid;
  logic [7:0]       robid  [DEPTH];
  logic [OPW-1:0]   op     [DEPTH];
  logic [DEPTH-1:0] rs1_rdy;
  logic [DEPTH-1:0] rs2_rdy;
  logic [31:0]      rs1_val[DEPTH];
  logic [31:0]      rs2_val[DEPTH];

  logic          wake;
  logic          take;
  logic          fire;
  logic          any_free;
  logic          any_ready;
  logic [IW-1:0] free_idx;
  logic [IW-1:0] sel_idx;
  logic          byp1;
  logic          byp2;
  logic          unused_robid_msb;

  assign unused_robid_msb = bus.wb_robid[7];

  assign wake = bus.wb_valid & ~bus.wb_error;
  assign take = bus.disp_valid & ~bus.rs_full & ~bus.rob_flush;
  assign fire = bus.issue_valid & bus.issue_ready;

  assign byp1 = wake & ~bus.disp_rs1_valid & (bus.disp_rs1_tagval[6:0] == bus.wb_robid[6:0]);
  assign byp2 = wake & ~bus.disp_rs2_valid & (bus.disp_rs2_tagval[6:0] == bus.wb_robid[6:0]);

  // Descending scans so the last hit is the lowest index.
  always_comb begin
    free_idx  = '0;
    sel_idx   = '0;
    any_free  = 1'b0;
    any_ready = 1'b0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (!valid[i]) begin
        free_idx = IW'(i);
        any_free = 1'b1;
      end
      if (valid[i] && rs1_rdy[i] && rs2_rdy[i]) begin
        sel_idx   = IW'(i);
        any_ready = 1'b1;
      end
    end
  end

  assign bus.rs_full     = ~any_free;
  assign bus.issue_valid = any_ready;
  assign bus.issue_robid = robid[sel_idx];
  assign bus.issue_op    = op[sel_idx];
  assign bus.issue_rs1   = rs1_val[sel_idx];
  assign bus.issue_rs2   = rs2_val[sel_idx];

  always_ff @(posedge clk) begin
    if (rst) begin
      valid <= '0;
    end else if (bus.rob_flush) begin
      valid <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (valid[i] && wake && !rs1_rdy[i] && rs1_val[i][6:0] == bus.wb_robid[6:0]) begin
          rs1_rdy[i] <= 1'b1;
          rs1_val[i] <= bus.wb_result;
        end
        if (valid[i] && wake && !rs2_rdy[i] && rs2_val[i][6:0] == bus.wb_robid[6:0]) begin
          rs2_rdy[i] <= 1'b1;
          rs2_val[i] <= bus.wb_result;
        end
      end
      if (fire) begin
        valid[sel_idx] <= 1'b0;
      end
      // The dispatch target was invalid before the edge, so it never collides with sel_idx.
      if (take) begin
        valid[free_idx]   <= 1'b1;
        robid[free_idx]   <= bus.disp_robid;
        op[free_idx]      <= bus.disp_op;
        rs1_rdy[free_idx] <= bus.disp_rs1_valid | byp1;
        rs2_rdy[free_idx] <= bus.disp_rs2_valid | byp2;
        rs1_val[free_idx] <= byp1 ? bus.wb_result : bus.disp_rs1_tagval;
        rs2_val[free_idx] <= byp2 ? bus.wb_result : bus.disp_rs2_tagval;
      end
    end
  end
endmodule

// File: tb/tb_rs_issue_queue.sv
// Directed bench for rs_issue_queue: dispatch, wakeup, bypass, full, ordering,
// flush and reset, against hand-computed expectations.
module tb_rs_issue_queue;
  logic clk;
  logic rst;
  int   n_checks;
  int   n_errors;

  rs_issue_queue_if #(.OPW(16)) bus ();

  rs_issue_queue #(.DEPTH(8), .OPW(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h, want 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.disp_valid      = 1'b0;
    bus.disp_robid      = '0;
    bus.disp_op         = '0;
    bus.disp_rs1_valid  = 1'b0;
    bus.disp_rs1_tagval = '0;
    bus.disp_rs2_valid  = 1'b0;
    bus.disp_rs2_tagval = '0;
    bus.wb_valid        = 1'b0;
    bus.wb_error        = 1'b0;
    bus.wb_robid        = '0;
    bus.wb_result       = '0;
    bus.rob_flush       = 1'b0;
  endtask

  task automatic disp(input logic [7:0] id, input logic v1, input logic [31:0] t1,
                      input logic v2, input logic [31:0] t2);
    bus.disp_valid      = 1'b1;
    bus.disp_robid      = id;
    bus.disp_op         = {8'hA5, id};
    bus.disp_rs1_valid  = v1;
    bus.disp_rs1_tagval = t1;
    bus.disp_rs2_valid  = v2;
    bus.disp_rs2_tagval = t2;
  endtask

  task automatic wb(input logic [7:0] id, input logic err, input logic [31:0] res);
    bus.wb_valid  = 1'b1;
    bus.wb_error  = err;
    bus.wb_robid  = id;
    bus.wb_result = res;
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    idle();
    bus.issue_ready = 1'b0;
    rst = 1'b1;
    tick();
    tick();
    chk("reset_issue_valid", 32'(bus.issue_valid), 32'd0);
    chk("reset_rs_full", 32'(bus.rs_full), 32'd0);
    rst = 1'b0;

    // Fully ready dispatch issues after one edge.
    disp(8'd5, 1'b1, 32'h11, 1'b1, 32'h22);
    tick();
    idle();
    chk("rdy_valid", 32'(bus.issue_valid), 32'd1);
    chk("rdy_robid", 32'(bus.issue_robid), 32'd5);
    chk("rdy_op", 32'(bus.issue_op), 32'hA505);
    chk("rdy_rs1", bus.issue_rs1, 32'h11);
    chk("rdy_rs2", bus.issue_rs2, 32'h22);
    bus.issue_ready = 1'b1;
    tick();
    bus.issue_ready = 1'b0;
    chk("rdy_empty", 32'(bus.issue_valid), 32'd0);

    // Wait on tag 3, then wake.
    disp(8'd9, 1'b0, 32'd3, 1'b1, 32'h99);
    tick();
    idle();
    chk("wait_c1", 32'(bus.issue_valid), 32'd0);
    tick();
    chk("wait_c2", 32'(bus.issue_valid), 32'd0);
    wb(8'd3, 1'b0, 32'hDEADBEEF);
    tick();
    idle();
    chk("wake_valid", 32'(bus.issue_valid), 32'd1);
    chk("wake_robid", 32'(bus.issue_robid), 32'd9);
    chk("wake_rs1", bus.issue_rs1, 32'hDEADBEEF);
    chk("wake_rs2", bus.issue_rs2, 32'h99);
    bus.issue_ready = 1'b1;
    tick();
    bus.issue_ready = 1'b0;
    chk("wake_empty", 32'(bus.issue_valid), 32'd0);

    // Errored writeback wakes nothing; flush clears the stuck entry.
    disp(8'd10, 1'b0, 32'd4, 1'b1, 32'h1);
    tick();
    idle();
    wb(8'd4, 1'b1, 32'h55);
    tick();
    idle();
    chk("err_c1", 32'(bus.issue_valid), 32'd0);
    tick();
    chk("err_c2", 32'(bus.issue_valid), 32'd0);
    bus.rob_flush = 1'b1;
    tick();
    idle();

    // Dispatch-time bypass.
    disp(8'd12, 1'b0, 32'd7, 1'b1, 32'h1);
    wb(8'd7, 1'b0, 32'h42);
    tick();
    idle();
    chk("byp_valid", 32'(bus.issue_valid), 32'd1);
    chk("byp_robid", 32'(bus.issue_robid), 32'd12);
    chk("byp_rs1", bus.issue_rs1, 32'h42);
    bus.issue_ready = 1'b1;
    tick();
    bus.issue_ready = 1'b0;
    chk("byp_empty", 32'(bus.issue_valid), 32'd0);

    // Fill all 8 entries; entry i is robid 20+i waiting on tag 30+i.
    for (int i = 0; i < 8; i++) begin
      chk("fill_not_full", 32'(bus.rs_full), 32'd0);
      disp(8'(20 + i), 1'b0, 32'(30 + i), 1'b1, 32'h0);
      tick();
    end
    idle();
    chk("fill_full", 32'(bus.rs_full), 32'd1);
    disp(8'd99, 1'b1, 32'h9, 1'b1, 32'h9);
    tick();
    idle();
    chk("drop_no_issue", 32'(bus.issue_valid), 32'd0);
    wb(8'd32, 1'b0, 32'hC0DE);
    tick();
    idle();
    chk("e2_valid", 32'(bus.issue_valid), 32'd1);
    chk("e2_robid", 32'(bus.issue_robid), 32'd22);
    chk("e2_rs1", bus.issue_rs1, 32'hC0DE);
    bus.issue_ready = 1'b1;
    chk("full_in_issue_cycle", 32'(bus.rs_full), 32'd1);
    tick();
    bus.issue_ready = 1'b0;
    chk("full_after_issue", 32'(bus.rs_full), 32'd0);
    chk("e2_gone", 32'(bus.issue_valid), 32'd0);
    disp(8'd50, 1'b1, 32'h50, 1'b1, 32'h51);
    tick();
    idle();
    chk("refill_full", 32'(bus.rs_full), 32'd1);
    chk("refill_robid", 32'(bus.issue_robid), 32'd50);
    // Waking entry 1 must pre-empt the refill, placing it above index 1.
    wb(8'd31, 1'b0, 32'h31);
    tick();
    idle();
    chk("e1_preempt", 32'(bus.issue_robid), 32'd21);
    bus.issue_ready = 1'b1;
    tick();
    chk("refill_next", 32'(bus.issue_robid), 32'd50);
    chk("refill_rs2", bus.issue_rs2, 32'h51);
    tick();
    bus.issue_ready = 1'b0;
    chk("refill_drained", 32'(bus.issue_valid), 32'd0);
    bus.rob_flush = 1'b1;
    tick();
    idle();
    chk("flush1_empty", 32'(bus.rs_full), 32'd0);

    // Entries 0..4 robid 60+i wait on tag 70+i; wake 4 then 1.
    for (int i = 0; i < 5; i++) begin
      disp(8'(60 + i), 1'b0, 32'(70 + i), 1'b1, 32'h0);
      tick();
    end
    idle();
    wb(8'd74, 1'b0, 32'h444);
    tick();
    idle();
    chk("e4_robid", 32'(bus.issue_robid), 32'd64);
    wb(8'd71, 1'b0, 32'h111);
    tick();
    idle();
    for (int c = 0; c < 3; c++) begin
      chk("hold_robid", 32'(bus.issue_robid), 32'd61);
      chk("hold_rs1", bus.issue_rs1, 32'h111);
      tick();
    end
    bus.issue_ready = 1'b1;
    chk("hs_first", 32'(bus.issue_robid), 32'd61);
    tick();
    chk("hs_second", 32'(bus.issue_robid), 32'd64);
    chk("hs_second_rs1", bus.issue_rs1, 32'h444);
    tick();
    bus.issue_ready = 1'b0;
    chk("hs_drained", 32'(bus.issue_valid), 32'd0);

    // Flush with concurrent dispatch and wakeup of entry 0 (robid 60).
    disp(8'd80, 1'b1, 32'h8, 1'b1, 32'h8);
    wb(8'd70, 1'b0, 32'h700);
    bus.rob_flush = 1'b1;
    bus.issue_ready = 1'b1;
    tick();
    idle();
    chk("flush_valid", 32'(bus.issue_valid), 32'd0);
    chk("flush_full", 32'(bus.rs_full), 32'd0);
    wb(8'd72, 1'b0, 32'h720);
    tick();
    idle();
    chk("flush_stays_empty", 32'(bus.issue_valid), 32'd0);
    bus.issue_ready = 1'b0;

    // Reset mid-operation wins over pending work and flush.
    disp(8'd90, 1'b1, 32'h1, 1'b1, 32'h2);
    tick();
    idle();
    chk("pre_rst_valid", 32'(bus.issue_valid), 32'd1);
    rst = 1'b1;
    bus.rob_flush = 1'b1;
    disp(8'd91, 1'b1, 32'h1, 1'b1, 32'h2);
    tick();
    idle();
    rst = 1'b0;
    chk("rst_mid_valid", 32'(bus.issue_valid), 32'd0);
    chk("rst_mid_full", 32'(bus.rs_full), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
